vitals_uart_tx: RTL and testbench
=================================

VITALS_UART_TX -- requirements
Module: vitals_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, CLOCK_50 cycles per UART bit (9600 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter HEADER, default 8'hAA, first byte of every frame.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to send one frame.
REQ-006 SAT  in  8  oxygen-saturation reading.
REQ-007 OX  in  8  oximetry / pulse reading.
REQ-008 TEMP  in  8  temperature reading.
REQ-009 tx  out  1  UART 8N1 serial line to the Bluetooth module; idles high.
REQ-010 busy  out  1  high from the cycle after an accepted start until the frame completes.
REQ-011 done  out  1  one-cycle pulse at frame completion.

Function
REQ-012 The block SHALL send a frame of 5 bytes, in order: HEADER, SAT, OX, TEMP, CHK.
REQ-013 CHK SHALL be (SAT + OX + TEMP) mod 256, computed from the latched values.
REQ-014 Each byte SHALL be sent 8N1, with bit timing as follows:
  - one start bit (0);
  - 8 data bits, LSB first;
  - one stop bit (1);
  - each bit held for exactly CLKS_PER_BIT cycles.
REQ-015 Bytes SHALL be sent back-to-back with no idle gap, so one frame is 50*CLKS_PER_BIT cycles.
REQ-016 start SHALL be accepted only in IDLE.
  - SAT/OX/TEMP are latched at that edge.
  - busy and tx=0 take effect at the next edge, k+1.
REQ-017 start while busy=1 SHALL be ignored, with no queuing and no effect on the frame in flight.
REQ-018 Input changes after acceptance SHALL NOT affect the frame in flight.
REQ-019 The state machine SHALL have these states and transitions:
  - IDLE -> START on an accepted start;
  - START -> DATA after CLKS_PER_BIT cycles;
  - DATA -> STOP after 8 bits;
  - STOP -> START if the byte index < 4;
  - STOP -> DONE if the byte index = 4;
  - DONE -> IDLE after one cycle.
REQ-020 With start accepted at edge k, the last stop bit SHALL end at edge k+1+50*CLKS_PER_BIT.
  - done=1 and busy=0 for exactly that one cycle.
  - tx=1 from then on.
REQ-021 A start asserted in the same cycle as done SHALL be ignored; the earliest new acceptance is the following cycle.
REQ-022 The bit counter, baud counter and byte index SHALL wrap only under FSM control.
  - The baud counter is sized ceil(log2(CLKS_PER_BIT)) bits and reloads at CLKS_PER_BIT-1.
  - The byte index is 3 bits and saturates at 4.
REQ-023 tx, busy and done SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-024 reset=0 at a rising edge SHALL force state IDLE, tx=1, busy=0, done=0, all counters 0 and latched bytes 0.
REQ-025 Reset mid-frame SHALL abort the frame.
  - tx=1 from the next edge.
  - No done pulse is produced.
  - start is ignored while reset=0.

Structure
REQ-026 CLKS_PER_BIT default, HEADER and the FSM state encoding SHALL live in shared package satempox_pkg.
REQ-027 Serialization SHALL be in one sub-module, uart_tx_byte (load/data in; tx/ready out).
  - vitals_uart_tx holds the frame sequencer and checksum.

Verification
REQ-028 Use CLKS_PER_BIT=4 in simulation.
  - Stimulus: SAT=35, OX=62, TEMP=97, start at edge k.
  - Required: tx decodes to AA 23 3E 61 C2; done pulses at k+201; busy is high k+1..k+200.
REQ-029 Checksum wrap.
  - Stimulus: SAT=200, OX=100, TEMP=50.
  - Required: CHK=0x5E; the byte sequence is AA C8 64 32 5E.
REQ-030 Ignored start.
  - Stimulus: start pulsed at k+40 and at k+201 (the done cycle) during the frame from REQ-028.
  - Required: exactly one frame; tx=1 and busy=0 at k+202..k+260.
REQ-031 Reset mid-frame.
  - Stimulus: reset=0 at k+90 during byte OX.
  - Required: tx=1 and busy=0 from k+91; no done pulse.
  - Then: a new start after reset=1 produces a complete correct frame.
REQ-032 Input stability.
  - Stimulus: change SAT/OX/TEMP every cycle after acceptance.
  - Required: the frame carries the values latched at acceptance; bit widths are exactly 4 cycles, measured on tx.

Source files
------------

// File: rtl/satempox_pkg.sv
// Shared definitions for the vitals UART transmitter: default timing, frame
// header, FSM state encodings and the frame checksum.
package satempox_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;
  localparam logic [7:0]  HEADER_DEFAULT       = 8'hAA;

  // Byte index of the checksum, the last byte of a frame.
  localparam logic [2:0]  LAST_BYTE_IDX        = 3'd4;

  // Bit-level states of the byte serializer.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Frame-level states of the sequencer.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] sat,
                                                input logic [7:0] ox,
                                                input logic [7:0] temp);
    return sat + ox + temp;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; accepts a new byte in the last cycle of the previous
// stop bit so consecutive bytes leave with no idle gap.
module uart_tx_byte
  import satempox_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned      BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    bit_end = (baud_q == BAUD_LAST);
    ready   = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);

    if (state_q != TX_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      TX_IDLE: ;
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A load overrides the stop-to-idle step so the next start bit follows directly.
    if (ready && load) begin
      state_d = TX_START;
      baud_d  = '0;
      shift_d = data;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/vitals_uart_tx.sv
// Frame sequencer: latches SAT/OX/TEMP on start and streams
// HEADER, SAT, OX, TEMP, CHK through the byte serializer back-to-back.
module vitals_uart_tx
  import satempox_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] SAT,
  input  logic [7:0] OX,
  input  logic [7:0] TEMP,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  seq_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sat_q, sat_d;
  logic [7:0] ox_q, ox_d;
  logic [7:0] temp_q, temp_d;
  logic [7:0] chk_q, chk_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       finish;
  logic       byte_load;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_tx;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sat_d     = sat_q;
    ox_d      = ox_q;
    temp_d    = temp_q;
    chk_d     = chk_q;
    finish    = 1'b0;
    byte_load = 1'b0;
    byte_data = HEADER;

    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_LOAD;
          idx_d   = 3'd0;
          sat_d   = SAT;
          ox_d    = OX;
          temp_d  = TEMP;
          chk_d   = frame_checksum(SAT, OX, TEMP);
        end
      end
      SEQ_LOAD: begin
        byte_load = 1'b1;
        state_d   = SEQ_RUN;
      end
      SEQ_RUN: begin
        // The serializer only reports ready in the final cycle of a stop bit.
        if (byte_ready) begin
          if (idx_q < LAST_BYTE_IDX) begin
            byte_load = 1'b1;
            idx_d     = idx_q + 3'd1;
            unique case (idx_q)
              3'd0:    byte_data = sat_q;
              3'd1:    byte_data = ox_q;
              3'd2:    byte_data = temp_q;
              default: byte_data = chk_q;
            endcase
          end else begin
            finish  = 1'b1;
            state_d = SEQ_DONE;
          end
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase

    busy_d = ((state_q == SEQ_LOAD) || (state_q == SEQ_RUN)) && !finish;
    done_d = finish;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      sat_q   <= '0;
      ox_q    <= '0;
      temp_q  <= '0;
      chk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      ox_q    <= ox_d;
      temp_q  <= temp_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .load    (byte_load),
    .data    (byte_data),
    .tx      (byte_tx),
    .ready   (byte_ready)
  );

  assign tx   = byte_tx;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_vitals_uart_tx.sv
// Scoreboard bench for vitals_uart_tx at 4 clocks per bit: frames push their
// expected bytes, a UART monitor decodes tx and pops/compares independently.
module tb_vitals_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] SAT, OX, TEMP;
  logic       tx, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  bit         abort_seen = 1'b0;

  vitals_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hAA)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .start   (start),
    .SAT     (SAT),
    .OX      (OX),
    .TEMP    (TEMP),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  always @(posedge clk) if (reset === 1'b0) abort_seen = 1'b1;

  // UART monitor: four samples per bit on the falling edge, one byte compare each.
  initial begin : monitor
    logic [39:0] w;
    logic [7:0]  b;
    int          ok;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        abort_seen = 1'b0;
        w[0] = tx;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          w[i] = tx;
        end
        if (!abort_seen) begin
          ok = 1;
          for (int j = 0; j < 10; j++)
            for (int m = 1; m < 4; m++)
              if (w[4*j+m] !== w[4*j]) ok = 0;
          if (w[36] !== 1'b1) ok = 0;
          for (int j = 0; j < 8; j++) b[j] = w[4*(j+1)];
          check("bit_width_and_stop", ok, 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected none", b);
          end else begin
            check("frame_byte", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  // One frame accepted at edge k; r counts edges after k.
  task automatic run_frame(input logic [7:0] s, input logic [7:0] o,
                           input logic [7:0] t, input logic [7:0] chk,
                           input bit ignore_starts, input bit scramble,
                           input int reset_at);
    int busy_err = 0, idle_err = 0, done_cnt = 0, done_at = -1, last_r;
    logic tx_k1 = 1'b1;
    last_r = (reset_at > 0) ? 150 : 260;
    exp_q.push_back(8'hAA);
    exp_q.push_back(s);
    exp_q.push_back(o);
    exp_q.push_back(t);
    exp_q.push_back(chk);
    SAT = s; OX = o; TEMP = t; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_at_accept_edge", busy, 0);
    for (int r = 1; r <= last_r; r++) begin
      if (scramble) begin
        SAT = 8'($urandom); OX = 8'($urandom); TEMP = 8'($urandom);
      end
      if (ignore_starts) start = (r == 40) || (r == 201) || (r == 202);
      if (reset_at > 0) begin
        reset = !(r >= reset_at && r < reset_at + 3);
        start = (r == reset_at + 1);
      end
      @(posedge clk);
      @(negedge clk);
      if (r == 1) tx_k1 = tx;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = r;
      end
      if (reset_at > 0) begin
        if (r < reset_at && busy !== 1'b1) busy_err++;
        if (r > reset_at && (tx !== 1'b1 || busy !== 1'b0)) idle_err++;
      end else begin
        if (r <= 200 && busy !== 1'b1) busy_err++;
        if (r == 201 && busy !== 1'b0) busy_err++;
        if (r >= 202 && (tx !== 1'b1 || busy !== 1'b0)) idle_err++;
      end
    end
    start = 1'b0;
    reset = 1'b1;
    check("tx_start_bit_at_k1", tx_k1, 0);
    check("busy_window_errors", busy_err, 0);
    check("idle_after_frame_errors", idle_err, 0);
    if (reset_at > 0) begin
      check("done_pulses_after_abort", done_cnt, 0);
      exp_q.delete();
    end else begin
      check("done_pulse_count", done_cnt, 1);
      check("done_edge_offset", done_at, 201);
    end
  endtask

  initial begin : stimulus
    reset = 1'b0;
    start = 1'b0;
    SAT = '0; OX = '0; TEMP = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    // 35+62+97 = 194 = C2, with starts at k+40 and around the done cycle
    run_frame(8'd35, 8'd62, 8'd97, 8'hC2, 1'b1, 1'b0, 0);
    // 200+100+50 = 350 -> 5E after wrap
    run_frame(8'd200, 8'd100, 8'd50, 8'h5E, 1'b0, 1'b0, 0);
    // reset pulled low at k+90 during OX
    run_frame(8'd35, 8'd62, 8'd97, 8'hC2, 1'b0, 1'b0, 90);
    // clean frame after the abort: 12+34+56 = 9C
    run_frame(8'h12, 8'h34, 8'h56, 8'h9C, 1'b0, 1'b0, 0);
    // inputs scrambled every cycle after acceptance: FF+01+80 = 80
    run_frame(8'hFF, 8'h01, 8'h80, 8'h80, 1'b0, 1'b1, 0);

    repeat (50) @(negedge clk);
    check("all_expected_bytes_seen", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
